next_pc_unit: RTL and testbench
===============================

# next_pc_unit

Parametrised next-PC generator for the RV32I core. It owns the fetch PC register and resolves all control-flow instructions at execute: BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR. Comparison and target arithmetic are done internally. An optional direct-mapped branch target buffer (BTB) with 2-bit counters predicts at fetch. On a misprediction it raises a flush and redirects the PC on the next edge.

## Interface
- `XLEN`, 32: datapath/address width; only 32 is supported.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `BTB_DEPTH`, 16: number of BTB entries; power of two, ≥2. `IDX = log2(BTB_DEPTH)`.
- `clk` in 1: the block's one clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `fetch_stall` in 1: hold the PC.
- `pc` out XLEN: current fetch PC (registered).
- `pred_taken` out 1: fetch-stage prediction for `pc` (combinational).
- `pred_target` out XLEN: predicted target for `pc` (combinational).
- `ex_valid` in 1: execute-stage slot holds a live instruction.
- `ex_inst` in 32: execute-stage instruction word.
- `ex_pc` in XLEN: PC of `ex_inst`.
- `ex_rs1`, `ex_rs2` in XLEN: forwarded operand values.
- `ex_pred_taken` in 1: prediction made for `ex_inst` at fetch, carried down the pipe.
- `ex_pred_target` in XLEN: matching predicted target.
- `flush` out 1: kill younger instructions (combinational).
- `link_addr` out XLEN: `ex_pc + 4`, for JAL/JALR writeback.
- `misalign` out 1: resolved taken target has bit 1 set (combinational).

## Operation
- Decode on `ex_inst[6:0]`: BRANCH 1100011, JAL 1101111, JALR 1100111. Any other opcode is non-control-flow (`cf=0`).
- Immediates follow the standard encodings with imm[0]=0:
  - B-type: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - J-type: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - I-type: inst[31:20].
  - All sign-extended to XLEN.
- Branch condition is selected by funct3 = `ex_inst[14:12]`:
  - 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE.
  - 010 and 011 mean never taken.
- Target:
  - Branch and JAL: `ex_pc + imm`.
  - JALR: `(ex_rs1 + imm) & ~1`.
  - All sums are modulo 2^XLEN; wrap-around is silent.
- `taken`: condition true for a branch; always 1 for JAL/JALR; 0 if `cf=0`.
- Mispredict, `mp = ex_valid & !misalign & (ex_pred_taken != taken | (taken & ex_pred_target != target))`.
  - This covers a non-cf instruction predicted taken through a BTB alias; the redirect then goes to `ex_pc+4`.
- `misalign = ex_valid & taken & target[1]`. It suppresses redirect, flush and BTB update; traps are handled elsewhere.
- `flush = mp`. Redirect address = `taken ? target : ex_pc+4`.
- PC next-state priority, highest first:
  - `mp`: redirect address.
  - `fetch_stall`: hold.
  - `pred_taken`: `pred_target`.
  - Otherwise `pc+4`.
- A redirect wins over a simultaneous stall.

## Timing
- Reset: `pc=RESET_PC` and all BTB valid bits cleared. Consequently `pred_taken=0`, `pred_target=0`, and `flush=0`/`misalign=0` whenever `ex_valid=0`.
- Prediction: zero-cycle combinational lookup on `pc`.
- Resolution: `flush` is high in the same cycle as the resolving `ex_valid`. `pc` equals the redirect address after the next rising edge, so redirect latency is 1 cycle.
- BTB update, on the same edge, when `ex_valid & cf & !misalign`:
  - Index `ex_pc[IDX+1:2]`; tag `ex_pc[XLEN-1:IDX+2]`.
  - Tag hit: the counter saturates up if `taken`, down if not, and the target is rewritten when `taken`.
  - Miss and `taken`: allocate the entry, replacing any occupant, with counter 10 for a branch or 11 for JAL/JALR.
  - Miss and not taken: no change.
- A lookup and an update to the same index in one cycle: the lookup sees the old contents.
- `rst_n` asserted mid-operation immediately forces the reset state. Any in-flight redirect is lost.

## Configuration
- `NEXT_PC_BTB_EN` defined: the BTB is built as described.
- Undefined: no BTB storage. `pred_taken=0` and `pred_target=0` permanently, giving static not-taken. Every taken cf instruction mispredicts, and resolution, flush and redirect behave identically otherwise.

## Test plan
- Reset release with `RESET_PC=32'h100` and no stall -> `pc` goes 100, 104, 108 on successive edges; `flush=0`.
- BEQ at `ex_pc=0x200`, imm +16, rs1=rs2=5, `ex_pred_taken=0` -> `flush=1` that cycle; `pc=0x210` next edge; BTB entry allocated with counter 10.
- BLTU rs1=1, rs2=0xFFFF_FFFF versus BLT with the same operands -> BLTU taken, BLT not taken; redirect to target and to `ex_pc+4` respectively when predicted opposite.
- JALR rs1=0x1001, imm 0x7 -> target 0x1008, `link_addr=ex_pc+4`; with rs1=0x1002, imm 0 -> `misalign=1`, `flush=0`, `pc` continues sequentially.
- With `NEXT_PC_BTB_EN` defined, the same taken branch resolved twice -> the second fetch of 0x200 shows `pred_taken=1`, `pred_target=0x210`; correct resolution gives `flush=0`.
- `fetch_stall=1` together with a mispredict -> `pc` takes the redirect; in the following stalled cycle without a mispredict, `pc` holds.

Source files
------------

// File: rtl/next_pc_unit_if.sv
// Fetch/execute control-flow bundle for next_pc_unit.
// slave = the PC unit, master = the pipeline around it.
interface next_pc_unit_if #(
  parameter int XLEN = 32
);
  logic            fetch_stall;
  logic [XLEN-1:0] pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid;
  logic [31:0]     ex_inst;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            flush;
  logic [XLEN-1:0] link_addr;
  logic            misalign;

  modport master (
    output fetch_stall, ex_valid, ex_inst, ex_pc,
    output ex_rs1, ex_rs2, ex_pred_taken, ex_pred_target,
    input  pc, pred_taken, pred_target,
    input  flush, link_addr, misalign
  );

  modport slave (
    input  fetch_stall, ex_valid, ex_inst, ex_pc,
    input  ex_rs1, ex_rs2, ex_pred_taken, ex_pred_target,
    output pc, pred_taken, pred_target,
    output flush, link_addr, misalign
  );
endinterface

// File: rtl/next_pc_unit.sv
// Fetch PC register, execute-stage branch/jump resolution and
// optional BTB predictor (enable with `define NEXT_PC_BTB_EN).
module next_pc_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BTB_DEPTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  next_pc_unit_if.slave io
);
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  if (XLEN != 32) begin : g_bad_xlen
    $error("next_pc_unit: only XLEN=32 is supported");
  end
  if (BTB_DEPTH < 2 || (BTB_DEPTH & (BTB_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("next_pc_unit: BTB_DEPTH must be a power of two >= 2");
  end

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic            is_br;
  logic            is_jal;
  logic            is_jalr;
  logic            cf;
  logic            cond;
  logic            taken;
  logic            mp;
  logic            eq;
  logic            lt;
  logic            ltu;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] sum_jr;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] redir;
  logic [XLEN-1:0] pc_nxt;

  assign opc = io.ex_inst[6:0];
  assign f3  = io.ex_inst[14:12];

  assign imm_b = {{(XLEN-12){io.ex_inst[31]}}, io.ex_inst[7],
                  io.ex_inst[30:25], io.ex_inst[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){io.ex_inst[31]}}, io.ex_inst[19:12],
                  io.ex_inst[20], io.ex_inst[30:21], 1'b0};
  assign imm_i = {{(XLEN-11){io.ex_inst[31]}}, io.ex_inst[30:20]};

  // Opcode class decode
  always_comb begin
    is_br   = 1'b0;
    is_jal  = 1'b0;
    is_jalr = 1'b0;
    unique case (1'b1)
      (opc == OP_BR):   is_br   = 1'b1;
      (opc == OP_JAL):  is_jal  = 1'b1;
      (opc == OP_JALR): is_jalr = 1'b1;
      default: ;
    endcase
  end

  assign cf  = is_br | is_jal | is_jalr;
  assign eq  = io.ex_rs1 == io.ex_rs2;
  assign lt  = $signed(io.ex_rs1) < $signed(io.ex_rs2);
  assign ltu = io.ex_rs1 < io.ex_rs2;

  // Branch condition by funct3; 010/011 never taken
  always_comb begin
    cond = 1'b0;
    case (f3)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt;
      3'b101:  cond = !lt;
      3'b110:  cond = ltu;
      3'b111:  cond = !ltu;
      default: cond = 1'b0;
    endcase
  end

  assign sum_jr = io.ex_rs1 + imm_i;
  assign target = is_jalr
                ? (sum_jr & ~{{(XLEN-1){1'b0}}, 1'b1})
                : io.ex_pc + (is_jal ? imm_j : imm_b);
  assign taken  = (is_br & cond) | is_jal | is_jalr;
  assign link   = io.ex_pc + XLEN'(4);
  assign redir  = taken ? target : link;

  assign io.misalign  = io.ex_valid & taken & target[1];
  assign mp = io.ex_valid & !io.misalign &
              ((io.ex_pred_taken != taken) |
               (taken & (io.ex_pred_target != target)));
  assign io.flush     = mp;
  assign io.link_addr = link;

  // Next fetch PC: redirect beats stall beats prediction
  always_comb begin
    pc_nxt = io.pc + XLEN'(4);
    priority case (1'b1)
      mp:             pc_nxt = redir;
      io.fetch_stall: pc_nxt = io.pc;
      io.pred_taken:  pc_nxt = io.pred_target;
      default: ;
    endcase
  end

  // Fetch PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) io.pc <= RESET_PC;
    else        io.pc <= pc_nxt;
  end

`ifdef NEXT_PC_BTB_EN
  localparam int IDX  = $clog2(BTB_DEPTH);
  localparam int TAGW = XLEN - IDX - 2;

  logic [BTB_DEPTH-1:0] btb_vld;
  logic [TAGW-1:0]      btb_tag [BTB_DEPTH];
  logic [XLEN-1:0]      btb_tgt [BTB_DEPTH];
  logic [1:0]           btb_ctr [BTB_DEPTH];
  logic [IDX-1:0]       f_idx;
  logic [IDX-1:0]       u_idx;
  logic [TAGW-1:0]      f_tag;
  logic [TAGW-1:0]      u_tag;
  logic                 f_hit;
  logic                 u_hit;
  logic                 upd;
  logic [1:0]           ctr_nxt;

  assign f_idx = io.pc[IDX+1:2];
  assign f_tag = io.pc[XLEN-1:IDX+2];
  assign f_hit = btb_vld[f_idx] && (btb_tag[f_idx] == f_tag);
  assign io.pred_taken  = f_hit & btb_ctr[f_idx][1];
  assign io.pred_target = io.pred_taken ? btb_tgt[f_idx] : '0;

  assign u_idx = io.ex_pc[IDX+1:2];
  assign u_tag = io.ex_pc[XLEN-1:IDX+2];
  assign u_hit = btb_vld[u_idx] && (btb_tag[u_idx] == u_tag);
  assign upd   = io.ex_valid & cf & !io.misalign;

  // Saturating 2-bit counter step
  always_comb begin
    ctr_nxt = btb_ctr[u_idx];
    if (taken && btb_ctr[u_idx] != 2'b11)
      ctr_nxt = btb_ctr[u_idx] + 2'd1;
    else if (!taken && btb_ctr[u_idx] != 2'b00)
      ctr_nxt = btb_ctr[u_idx] - 2'd1;
  end

  // BTB train on hit, allocate on taken miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_vld <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_tag[i] <= '0;
        btb_tgt[i] <= '0;
        btb_ctr[i] <= '0;
      end
    end else if (upd) begin
      if (u_hit) begin
        btb_ctr[u_idx] <= ctr_nxt;
        if (taken) btb_tgt[u_idx] <= target;
      end else if (taken) begin
        btb_vld[u_idx] <= 1'b1;
        btb_tag[u_idx] <= u_tag;
        btb_tgt[u_idx] <= target;
        btb_ctr[u_idx] <= is_br ? 2'b10 : 2'b11;
      end
    end
  end
`else
  assign io.pred_taken  = 1'b0;
  assign io.pred_target = '0;
`endif
endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: vector table plus
// reset, stall, async reset and BTB sequences.
module tb_next_pc_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  next_pc_unit_if #(.XLEN(32)) bus ();

  next_pc_unit #(
    .XLEN(32),
    .RESET_PC(32'h0000_0100),
    .BTB_DEPTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(bus)
  );

`ifdef NEXT_PC_BTB_EN
  localparam logic BTB_ON = 1'b1;
`else
  localparam logic BTB_ON = 1'b0;
`endif

  typedef struct {
    logic        vld;
    logic [31:0] inst;
    logic [31:0] epc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        ptk;
    logic [31:0] ptgt;
    logic        xfl;
    logic        xmis;
    logic [31:0] xredir;
  } vec_t;

  localparam int NV = 20;
  vec_t tv [NV];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;

  function automatic logic [31:0] enc_b(input logic [2:0] f3,
                                        input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3,
            imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12],
            5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm);
    return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  function automatic vec_t mk(
    input logic vld, input logic [31:0] inst, input logic [31:0] epc,
    input logic [31:0] rs1, input logic [31:0] rs2,
    input logic ptk, input logic [31:0] ptgt,
    input logic xfl, input logic xmis, input logic [31:0] xredir);
    vec_t v;
    v.vld = vld; v.inst = inst; v.epc = epc;
    v.rs1 = rs1; v.rs2 = rs2; v.ptk = ptk; v.ptgt = ptgt;
    v.xfl = xfl; v.xmis = xmis; v.xredir = xredir;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic set_ex(input logic vld, input logic [31:0] inst,
                        input logic [31:0] epc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic ptk,
                        input logic [31:0] ptgt);
    bus.ex_valid       = vld;
    bus.ex_inst        = inst;
    bus.ex_pc          = epc;
    bus.ex_rs1         = rs1;
    bus.ex_rs2         = rs2;
    bus.ex_pred_taken  = ptk;
    bus.ex_pred_target = ptgt;
  endtask

  initial begin
    logic [31:0] addi;
    addi = 32'h0010_0093;

    tv[0]  = mk(1, enc_b(3'b000, 13'd16), 32'h200, 5, 5, 0, 0, 1, 0, 32'h210);
    tv[1]  = mk(1, enc_b(3'b000, 13'd16), 32'h200, 5, 6, 0, 0, 0, 0, 0);
    tv[2]  = mk(1, enc_b(3'b001, 13'd16), 32'h200, 5, 6, 0, 0, 1, 0, 32'h210);
    tv[3]  = mk(1, enc_b(3'b110, 13'd16), 32'h300, 1, 32'hFFFF_FFFF,
                0, 0, 1, 0, 32'h310);
    tv[4]  = mk(1, enc_b(3'b100, 13'd16), 32'h300, 1, 32'hFFFF_FFFF,
                1, 32'h310, 1, 0, 32'h304);
    tv[5]  = mk(1, enc_b(3'b101, 13'd16), 32'h300, 1, 32'hFFFF_FFFF,
                1, 32'h310, 0, 0, 0);
    tv[6]  = mk(1, enc_b(3'b111, 13'd16), 32'h300, 1, 32'hFFFF_FFFF,
                0, 0, 0, 0, 0);
    tv[7]  = mk(1, enc_b(3'b010, 13'd16), 32'h300, 5, 5,
                1, 32'h310, 1, 0, 32'h304);
    tv[8]  = mk(1, enc_b(3'b000, 13'h1FF8), 32'h400, 7, 7, 0, 0, 1, 0, 32'h3F8);
    tv[9]  = mk(1, enc_j(21'h800), 32'h500, 0, 0, 0, 0, 1, 0, 32'hD00);
    tv[10] = mk(1, enc_j(21'h800), 32'h500, 0, 0, 1, 32'hD00, 0, 0, 0);
    tv[11] = mk(1, enc_j(21'h800), 32'h500, 0, 0, 1, 32'hC00, 1, 0, 32'hD00);
    tv[12] = mk(1, enc_i(12'h007), 32'h600, 32'h1001, 0, 0, 0, 1, 0, 32'h1008);
    tv[13] = mk(1, enc_i(12'h000), 32'h600, 32'h1002, 0, 0, 0, 0, 1, 0);
    tv[14] = mk(1, addi, 32'h700, 0, 0, 1, 32'h700, 1, 0, 32'h704);
    tv[15] = mk(1, addi, 32'h700, 0, 0, 0, 0, 0, 0, 0);
    tv[16] = mk(0, enc_b(3'b000, 13'd16), 32'h200, 5, 5, 0, 0, 0, 0, 0);
    tv[17] = mk(1, enc_j(21'h20), 32'hFFFF_FFF0, 0, 0, 0, 0, 1, 0, 32'h10);
    tv[18] = mk(1, enc_i(12'hFFD), 32'h640, 32'h2000, 0, 0, 0, 1, 0, 32'h1FFC);
    tv[19] = mk(1, enc_b(3'b000, 13'd6), 32'h200, 9, 9, 0, 0, 0, 1, 0);

    // reset state and sequential fetch
    bus.fetch_stall = 1'b0;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst pc", bus.pc, 32'h100);
    chk("rst pred_taken", bus.pred_taken, 0);
    chk("rst pred_target", bus.pred_target, 0);
    chk("rst flush", bus.flush, 0);
    chk("rst misalign", bus.misalign, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("seq pc1", bus.pc, 32'h104);
    chk("seq flush", bus.flush, 0);
    @(posedge clk); #1;
    chk("seq pc2", bus.pc, 32'h108);
    exp_pc = 32'h108;

    // vector table, fetch held so only redirects move pc
    bus.fetch_stall = 1'b1;
    for (int k = 0; k < NV; k++) begin
      set_ex(tv[k].vld, tv[k].inst, tv[k].epc, tv[k].rs1,
             tv[k].rs2, tv[k].ptk, tv[k].ptgt);
      #1;
      chk($sformatf("v%0d flush", k), bus.flush, tv[k].xfl);
      chk($sformatf("v%0d misalign", k), bus.misalign, tv[k].xmis);
      chk($sformatf("v%0d link", k), bus.link_addr, tv[k].epc + 32'd4);
      @(posedge clk); #1;
      if (tv[k].xfl) exp_pc = tv[k].xredir;
      chk($sformatf("v%0d pc", k), bus.pc, exp_pc);
    end

    // redirect beats stall, then stall holds
    set_ex(1, enc_b(3'b000, 13'd16), 32'h800, 3, 3, 0, 0);
    #1;
    chk("stall flush", bus.flush, 1);
    @(posedge clk); #1;
    chk("stall redirect pc", bus.pc, 32'h810);
    set_ex(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("stall hold pc", bus.pc, 32'h810);

    // async reset during a redirect
    bus.fetch_stall = 1'b0;
    set_ex(1, enc_b(3'b000, 13'd16), 32'h200, 5, 5, 0, 0);
    #1;
    chk("arst flush", bus.flush, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst pc now", bus.pc, 32'h100);
    set_ex(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("arst pc held", bus.pc, 32'h100);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst redirect lost", bus.pc, 32'h104);

    // BTB train at 0x200, then fetch 0x200
    bus.fetch_stall = 1'b1;
    set_ex(1, enc_b(3'b000, 13'd16), 32'h200, 5, 5, 0, 0);
    #1;
    chk("btb a flush", bus.flush, 1);
    @(posedge clk); #1;
    chk("btb a pc", bus.pc, 32'h210);
    set_ex(1, enc_b(3'b000, 13'd16), 32'h200, 5, 5, 0, 0);
    #1;
    chk("btb b flush", bus.flush, 1);
    @(posedge clk); #1;
    set_ex(1, addi, 32'h1FC, 0, 0, 1, 32'h300);
    #1;
    chk("alias flush", bus.flush, 1);
    @(posedge clk); #1;
    chk("alias pc", bus.pc, 32'h200);
    bus.fetch_stall = 1'b0;
    set_ex(1, enc_b(3'b000, 13'd16), 32'h200, 5, 5, 1, 32'h210);
    #1;
    chk("btb pred_taken", bus.pred_taken, BTB_ON);
    chk("btb pred_target", bus.pred_target, BTB_ON ? 32'h210 : 32'h0);
    chk("btb hit flush", bus.flush, 0);
    @(posedge clk); #1;
    chk("btb next pc", bus.pc, BTB_ON ? 32'h210 : 32'h204);
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("idle flush", bus.flush, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
